// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle layout and slice-count limits.
package pipe_pkg;

    typedef struct packed {
        logic MemtoReg;
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic Branch;
    } ctrl_t;

    localparam int CTRL_W_DEFAULT = 5;
    localparam int DEPTH_MAX      = 4;

endpackage

// File: rtl/pipe_slice.sv
// One pipeline register slice: valid/ctrl/data with stall hold, flush kill and
// bubble gating so an invalid slice never presents a nonzero control bundle.
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic [CTRL_W-1:0] inCtrl,
    input  logic [DATA_W-1:0] inData,
    output logic              outValid,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [DATA_W-1:0] outData
);

    logic              validQ;
    logic [CTRL_W-1:0] ctrlQ;
    logic [DATA_W-1:0] dataQ;

    // Flush leaves data untouched; only valid and ctrl matter once killed.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= 1'b0;
            ctrlQ  <= '0;
            dataQ  <= '0;
        end else if (flush) begin
            validQ <= 1'b0;
            ctrlQ  <= '0;
        end else if (!stall) begin
            validQ <= inValid;
            ctrlQ  <= inValid ? inCtrl : '0;
            dataQ  <= inValid ? inData : '0;
        end
    end

    assign outValid = validQ;
    assign outCtrl  = validQ ? ctrlQ : '0;
    assign outData  = dataQ;

endmodule

// File: rtl/pipe_stage_reg.sv
// Cascaded pipeline stage register (DEPTH slices) with stall/bubble counters.
// Optional per-edge trace output enabled by macro PIPE_STAGE_TRACE_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : gDepthCheck
        $fatal(1, "pipe_stage_reg: DEPTH=%0d outside 1..%0d", DEPTH, DEPTH_MAX);
    end

    // Index 0 is the stage input; index DEPTH is the last slice.
    logic              chainValid [DEPTH+1];
    logic [CTRL_W-1:0] chainCtrl  [DEPTH+1];
    logic [DATA_W-1:0] chainData  [DEPTH+1];

    assign chainValid[0] = in_valid;
    assign chainCtrl[0]  = in_ctrl;
    assign chainData[0]  = in_data;

    for (genvar i = 0; i < DEPTH; i++) begin : gSlice
        pipe_slice #(
            .DATA_W(DATA_W),
            .CTRL_W(CTRL_W)
        ) uSlice (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall),
            .flush   (flush),
            .inValid (chainValid[i]),
            .inCtrl  (chainCtrl[i]),
            .inData  (chainData[i]),
            .outValid(chainValid[i+1]),
            .outCtrl (chainCtrl[i+1]),
            .outData (chainData[i+1])
        );
    end

    assign out_valid = chainValid[DEPTH];
    assign out_ctrl  = chainCtrl[DEPTH];
    assign out_data  = chainData[DEPTH];

    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] bubbleCnt;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (stall && !flush && stallCnt != '1)
                stallCnt <= stallCnt + CNT_W'(1);
            if (!out_valid && !stall && bubbleCnt != '1)
                bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = stallCnt;
    assign bubble_cnt = bubbleCnt;

`ifdef PIPE_STAGE_TRACE_EN
    always_ff @(posedge clk) begin
        $strobe("pipe_stage_reg: valid=%0b ctrl=%b data=%h stall=%0b flush=%0b",
                out_valid, out_ctrl, out_data, stall, flush);
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances (DEPTH 1/2/3, and a
// 4-bit counter build) driven by one shared stimulus sequence.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_ctrl;
    logic [31:0] in_data;
    logic        stall;
    logic        flush;

    logic        v1, v2, v3, v4;
    logic [4:0]  c1, c2, c3, c4;
    logic [31:0] d1, d2, d3, d4;
    logic [15:0] s1, s2, s3, b1, b2, b3;
    logic [3:0]  s4, b4;

    int unsigned total = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(v1), .out_ctrl(c1), .out_data(d1),
        .stall_cnt(s1), .bubble_cnt(b1));

    pipe_stage_reg #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(v2), .out_ctrl(c2), .out_data(d2),
        .stall_cnt(s2), .bubble_cnt(b2));

    pipe_stage_reg #(.DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(v3), .out_ctrl(c3), .out_data(d3),
        .stall_cnt(s3), .bubble_cnt(b3));

    pipe_stage_reg #(.DEPTH(1), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall(stall), .flush(flush), .out_valid(v4), .out_ctrl(c4), .out_data(d4),
        .stall_cnt(s4), .bubble_cnt(b4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        stall = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        stall = 1'b0; flush = 1'b0;

        // Reset state
        step();
        chk("rst_valid", 64'(v1), 64'h0);
        chk("rst_ctrl",  64'(c1), 64'h0);
        chk("rst_data",  64'(d1), 64'h0);
        chk("rst_stall_cnt",  64'(s1), 64'h0);
        chk("rst_bubble_cnt", 64'(b1), 64'h0);
        rst = 1'b0;

        // Idle after reset: outputs stay zero, one bubble counted
        step();
        chk("idle_valid", 64'(v1), 64'h0);
        chk("idle_ctrl",  64'(c1), 64'h0);
        chk("idle_data",  64'(d1), 64'h0);
        chk("idle_bubble_cnt", 64'(b1), 64'h1);

        // DEPTH=1 single transfer
        in_valid = 1'b1; in_ctrl = 5'b01011; in_data = 32'hDEAD_BEEF;
        step();
        chk("d1_valid", 64'(v1), 64'h1);
        chk("d1_ctrl",  64'(c1), 64'h0B);
        chk("d1_data",  64'(d1), 64'hDEAD_BEEF);
        chk("d3_not_yet", 64'(v3), 64'h0);

        // DEPTH=3 back-to-back 1,2,3
        doReset();
        in_valid = 1'b1; in_ctrl = 5'b00001; in_data = 32'h1;
        step(); chk("d3_e1_valid", 64'(v3), 64'h0);
        in_data = 32'h2;
        step(); chk("d3_e2_valid", 64'(v3), 64'h0);
        in_data = 32'h3;
        step();
        chk("d3_e3_valid", 64'(v3), 64'h1);
        chk("d3_e3_data",  64'(d3), 64'h1);
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        step(); chk("d3_e4_data", 64'(d3), 64'h2);
        step();
        chk("d3_e5_data",  64'(d3), 64'h3);
        chk("d3_e5_ctrl",  64'(c3), 64'h01);
        step();
        chk("d3_e6_valid", 64'(v3), 64'h0);
        chk("d3_e6_ctrl",  64'(c3), 64'h0);

        // DEPTH=2 stall for 4 cycles with 0xA at output, 0xB behind it
        doReset();
        in_valid = 1'b1; in_ctrl = 5'b00010; in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        chk("d2_pre_stall_data", 64'(d2), 64'hA);
        stall = 1'b1; in_data = 32'hC;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("d2_stall_data",  64'(d2), 64'hA);
            chk("d2_stall_valid", 64'(v2), 64'h1);
        end
        chk("d2_stall_cnt",   64'(s2), 64'h4);
        chk("cnt4_stall_cnt", 64'(s4), 64'h4);
        stall = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        step();
        chk("d2_release_data",  64'(d2), 64'hB);
        chk("d2_release_valid", 64'(v2), 64'h1);
        chk("d2_bubble_cnt",    64'(b2), 64'h2);

        // Stall and flush on the same edge
        doReset();
        in_valid = 1'b1; in_ctrl = 5'b11111; in_data = 32'h55;
        step();
        chk("sf_load_ctrl", 64'(c1), 64'h1F);
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; stall = 1'b1;
        step();
        chk("sf_hold_valid", 64'(v1), 64'h1);
        chk("sf_hold_ctrl",  64'(c1), 64'h1F);
        chk("sf_stall_cnt1", 64'(s1), 64'h1);
        flush = 1'b1;
        step();
        chk("sf_flush_valid", 64'(v1), 64'h0);
        chk("sf_flush_ctrl",  64'(c1), 64'h0);
        chk("sf_stall_cnt2",  64'(s1), 64'h1);
        flush = 1'b0; stall = 1'b0;

        // Reset during stall with data in flight, then restart latency
        doReset();
        in_valid = 1'b1; in_ctrl = 5'b00100; in_data = 32'h77;
        step();
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; stall = 1'b1;
        step();
        chk("rs_pre_valid",      64'(v1), 64'h1);
        chk("rs_pre_stall_cnt",  64'(s1), 64'h1);
        chk("rs_pre_bubble_cnt", 64'(b1), 64'h1);
        rst = 1'b1;
        step();
        chk("rs_valid",      64'(v1), 64'h0);
        chk("rs_ctrl",       64'(c1), 64'h0);
        chk("rs_data",       64'(d1), 64'h0);
        chk("rs_stall_cnt",  64'(s1), 64'h0);
        chk("rs_bubble_cnt", 64'(b1), 64'h0);
        chk("rs_d3_valid",   64'(v3), 64'h0);
        chk("rs_d3_data",    64'(d3), 64'h0);
        rst = 1'b0; stall = 1'b0;
        in_valid = 1'b1; in_ctrl = 5'b01000; in_data = 32'h99;
        step();
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        step();
        chk("rs_d3_lat2_valid", 64'(v3), 64'h0);
        step();
        chk("rs_d3_lat3_valid", 64'(v3), 64'h1);
        chk("rs_d3_lat3_data",  64'(d3), 64'h99);
        chk("rs_d3_lat3_ctrl",  64'(c3), 64'h08);

        // Counter saturation with CNT_W=4
        doReset();
        stall = 1'b1;
        repeat (20) step();
        chk("sat_cnt4_stall", 64'(s4), 64'hF);
        chk("sat_cnt16_stall", 64'(s1), 64'd20);
        stall = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the datapath payload (ALU result, store data, dest reg).
REQ-002 SHALL have parameter CTRL_W, default 5, meaning width of the control bundle (MemtoReg, RegWrite, MemRead, MemWrite, Branch).
REQ-003 SHALL have parameter DEPTH, default 1, legal range 1..4, meaning number of cascaded register slices.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of each performance counter.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-006 SHALL have ports: in_valid input 1 upstream instruction valid; in_ctrl input CTRL_W control bundle; in_data input DATA_W payload.
REQ-007 SHALL have ports: stall input 1 hold all slices; flush input 1 kill all slices.
REQ-008 SHALL have ports: out_valid output 1; out_ctrl output CTRL_W; out_data output DATA_W; stall_cnt output CNT_W; bubble_cnt output CNT_W.

Function
REQ-009 SHALL, with stall=0 and flush=0, shift {valid, ctrl, data} one slice per rising clk edge; input-to-output latency exactly DEPTH cycles.
REQ-010 SHALL, with stall=1 and flush=0, hold every slice unchanged; in_* ignored that cycle.
REQ-011 SHALL, with flush=1, clear valid and ctrl of every slice on the next edge; data may retain old value; flush has priority over stall.
REQ-012 SHALL drive out_ctrl as all-zero whenever out_valid=0 (bubble gating), so no write enable escapes an invalid slice.
REQ-013 SHALL drive out_valid, out_ctrl and out_data from the last slice registers only (plus the gating of REQ-012); no combinational in_* to out_* path.
REQ-014 SHALL increment stall_cnt on every edge where stall=1 and flush=0 and rst=0; saturate at 2^CNT_W-1, no wrap.
REQ-015 SHALL increment bubble_cnt on every edge where rst=0 and out_valid=0 and stall=0; saturate at 2^CNT_W-1, no wrap.
REQ-016 SHALL treat in_valid=0 as a bubble: slice loads valid=0, ctrl=0.

Reset
REQ-017 SHALL, on rst=1 at a rising edge, clear valid, ctrl and data of all slices and both counters to 0; rst overrides stall and flush.
REQ-018 SHALL, after reset with in_valid held 0, present out_valid=0, out_ctrl=0, out_data=0.
REQ-019 SHALL, on reset asserted mid-stream, discard all in-flight instructions; first post-reset valid input appears at output DEPTH cycles after it is accepted.

Configuration
REQ-020 SHALL, with macro PIPE_STAGE_TRACE_EN defined, print one $strobe line per clock edge reporting slice-DEPTH valid, each ctrl bit, and data in hex, plus stall/flush state.
REQ-021 SHALL, without PIPE_STAGE_TRACE_EN, contain no display/strobe statements; functional behaviour identical in both builds.

Structure
REQ-022 SHALL take from shared package pipe_pkg: packed struct typedef ctrl_t {MemtoReg, RegWrite, MemRead, MemWrite, Branch}, localparam CTRL_W_DEFAULT=5, localparam DEPTH_MAX=4.
REQ-023 SHALL instantiate DEPTH copies of sub-module pipe_slice (one register slice with stall/flush/rst, valid gating) via generate loop; counters stay in pipe_stage_reg.
REQ-024 SHALL reject DEPTH outside 1..4 at elaboration (fatal assertion).

Verification
REQ-025 SHALL cover: DEPTH=1, in_valid=1, in_ctrl=5'b01011, in_data=32'hDEAD_BEEF, one edge -> out_valid=1, out_ctrl=5'b01011, out_data=32'hDEAD_BEEF.
REQ-026 SHALL cover: DEPTH=3, back-to-back data 1,2,3 -> out_data 1,2,3 on edges 3,4,5; out_valid=0 before edge 3.
REQ-027 SHALL cover: DEPTH=2, pipe holding 0xA,0xB, stall=1 for 4 cycles -> outputs frozen at 0xA, stall_cnt=4; release -> 0xB next edge.
REQ-028 SHALL cover: stall=1 and flush=1 same edge with ctrl=5'b11111 in flight -> out_valid=0, out_ctrl=0, stall_cnt unchanged.
REQ-029 SHALL cover: rst=1 during stall with valid data in flight -> all outputs 0, stall_cnt=0, bubble_cnt=0.
REQ-030 SHALL cover: CNT_W=4, stall held 20 cycles -> stall_cnt saturates at 15.
